// File: rtl/arbitro_jogadores.sv
// arbitro_jogadores: buzzer arbiter and turn scheduler with answer timer, lockout and per-player saturating scores
module arbitro_jogadores #(
  parameter int NUM_JOG = 4,
  parameter int ID_W = 2,
  parameter int PLACAR_W = 4,
  parameter int TEMPO_RESPOSTA = 5000,
  parameter int TIMER_W = 13
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         inicia_rodada,
  input  logic                         cancela,
  input  logic                         zera_placar,
  input  logic [NUM_JOG-1:0]           botoes,
  input  logic                         resposta_pronta,
  input  logic                         resposta_certa,
  output logic [NUM_JOG-1:0]           concede,
  output logic [ID_W-1:0]              jogador_id,
  output logic                         ativo,
  output logic [NUM_JOG-1:0]           bloqueados,
  output logic                         rodada_fim,
  output logic                         houve_vencedor,
  output logic [NUM_JOG*PLACAR_W-1:0]  placares,
  output logic [3:0]                   db_estado
);
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ARMADO    = 3'd1,
    CONCEDIDO = 3'd2,
    VERIFICA  = 3'd3,
    FIM       = 3'd4
  } estado_t;
  estado_t estado;
  logic [NUM_JOG-1:0] botoes_ant, cand;
  logic [ID_W-1:0] ptr, venc, idx;
  logic achou, acerto;
  logic [TIMER_W-1:0] timer;
  logic [PLACAR_W-1:0] placar [NUM_JOG];
  assign cand = botoes & ~botoes_ant & ~bloqueados;
  assign acerto = (estado == CONCEDIDO) && !cancela && resposta_pronta && resposta_certa;
  always_comb db_estado = (estado inside {OCIOSO, ARMADO, CONCEDIDO, VERIFICA, FIM}) ? {1'b0, estado} : 4'hB;
  // round-robin: descending scan so the candidate closest to ptr is the last one written
  always_comb begin
    achou = 1'b0;
    venc = '0;
    idx = '0;
    for (int k = NUM_JOG-1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_JOG);
      if (cand[idx]) begin
        achou = 1'b1;
        venc = idx;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
      botoes_ant <= '0;
      ptr <= '0;
      timer <= '0;
      concede <= '0;
      jogador_id <= '0;
      ativo <= 1'b0;
      bloqueados <= '0;
      rodada_fim <= 1'b0;
      houve_vencedor <= 1'b0;
    end else begin
      botoes_ant <= botoes;
      concede <= '0;
      ativo <= 1'b0;
      rodada_fim <= 1'b0;
      if (cancela && estado != OCIOSO) estado <= OCIOSO;
      else case (estado)
        OCIOSO: if (inicia_rodada) begin
          estado <= ARMADO;
          bloqueados <= '0;
          houve_vencedor <= 1'b0;
        end
        ARMADO: if (achou) begin
          estado <= CONCEDIDO;
          jogador_id <= venc;
          timer <= '0;
          ptr <= ID_W'((int'(venc) + 1) % NUM_JOG);
          concede <= NUM_JOG'(1) << venc;
          ativo <= 1'b1;
        end
        CONCEDIDO: if (resposta_pronta && resposta_certa) begin
          estado <= FIM;
          houve_vencedor <= 1'b1;
          rodada_fim <= 1'b1;
        end else if (resposta_pronta || timer == TIMER_W'(TEMPO_RESPOSTA-1)) begin
          bloqueados[jogador_id] <= 1'b1;
          estado <= VERIFICA;
        end else begin
          timer <= timer + 1'b1;
          concede <= concede;
          ativo <= 1'b1;
        end
        VERIFICA: if (&bloqueados) begin
          estado <= FIM;
          houve_vencedor <= 1'b0;
          rodada_fim <= 1'b1;
        end else estado <= ARMADO;
        FIM: estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) for (int i = 0; i < NUM_JOG; i++) placar[i] <= '0;
    else if (zera_placar) for (int i = 0; i < NUM_JOG; i++) placar[i] <= '0;
    else if (acerto && placar[jogador_id] != '1) placar[jogador_id] <= placar[jogador_id] + 1'b1;
  end
  for (genvar g = 0; g < NUM_JOG; g++) begin : g_placar
    assign placares[g*PLACAR_W +: PLACAR_W] = placar[g];
  end
endmodule

// File: doc/arbitro_jogadores.md
Name: arbitro_jogadores

Overview:
- Multi-player buzzer arbiter and turn scheduler for the quiz datapath.
- Sits between the player push-buttons and the shared answer path (answer register / comparator): grants exactly one player the right to answer, times that player's answer, and locks out players who answer wrong or time out.
- Keeps a per-player saturating score.
- Signals end of round to the game control unit, which starts each round with a pulse.

Parameters:
- NUM_JOG, 4, number of players (2..8).
- ID_W, 2, width of player index; must satisfy 2^ID_W >= NUM_JOG.
- PLACAR_W, 4, per-player score width; scores saturate at 2^PLACAR_W-1.
- TEMPO_RESPOSTA, 5000, answer window in clock cycles after a grant.
- TIMER_W, 13, answer timer width; must satisfy 2^TIMER_W > TEMPO_RESPOSTA.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inicia_rodada  in  1  one-cycle pulse from control unit; arms a new round.
- cancela  in  1  aborts the round; return to OCIOSO with no score change.
- zera_placar  in  1  synchronous clear of all scores, any state.
- botoes  in  NUM_JOG  synchronised, debounced player buttons, active-high level.
- resposta_pronta  in  1  datapath pulse: the granted player's answer is registered and compared.
- resposta_certa  in  1  comparison result; valid only with resposta_pronta.
- concede  out  NUM_JOG  one-hot grant to the answering player; all zeros when nobody holds the turn.
- jogador_id  out  ID_W  index of the granted or last granted player.
- ativo  out  1  a player currently holds the turn.
- bloqueados  out  NUM_JOG  players locked out of the current round.
- rodada_fim  out  1  one-cycle pulse at end of round.
- houve_vencedor  out  1  valid with rodada_fim; 1 when a player answered correctly.
- placares  out  NUM_JOG*PLACAR_W  packed scores; player i occupies bits [i*PLACAR_W +: PLACAR_W].
- db_estado  out  4  debug state code.

Behaviour:
- Reset: all outputs 0, state OCIOSO, priority pointer 0, scores 0, button history 0.

Press detection:
- botoes_ant is registered every cycle in every state.
- A press is pressao[i] = botoes[i] & ~botoes_ant[i].
- A button already held when the round arms is not a press.

States (db_estado code in brackets):
- OCIOSO (0):
  - inicia_rodada -> ARMADO.
  - Clear bloqueados on that transition.
- ARMADO (1):
  - Candidates are pressao & ~bloqueados.
  - If any candidate exists, grant the first candidate found round-robin, starting at the priority pointer and wrapping at NUM_JOG-1 -> 0.
  - Load jogador_id, clear the timer, go to CONCEDIDO.
  - Set the pointer to winner+1, mod NUM_JOG.
  - Presses from blocked players are ignored.
- CONCEDIDO (2):
  - concede[jogador_id]=1 and ativo=1 (Moore outputs, so the first cycle is the cycle after the press edge).
  - The timer increments each cycle.
  - Presses by other players are ignored and are not queued.
  - resposta_pronta & resposta_certa -> increment the player's score (saturating; no increment at maximum); go to FIM, houve_vencedor=1.
  - resposta_pronta & ~resposta_certa -> set bloqueados[jogador_id] -> VERIFICA.
  - Timer == TEMPO_RESPOSTA-1 with no resposta_pronta -> set bloqueados[jogador_id] -> VERIFICA.
  - If resposta_pronta and the timer expiry coincide, resposta_pronta wins.
- VERIFICA (3):
  - All bloqueados set -> FIM with houve_vencedor=0.
  - Otherwise -> ARMADO.
- FIM (4):
  - rodada_fim=1 for exactly one cycle; houve_vencedor is held from the decision.
  - Next state OCIOSO.
  - jogador_id, bloqueados and houve_vencedor keep their values until the next inicia_rodada.

Other rules:
- cancela in any state other than OCIOSO -> OCIOSO next cycle.
  - concede and ativo drop to 0.
  - No rodada_fim pulse, no score change.
  - cancela has priority over every other event.
- inicia_rodada outside OCIOSO is ignored.
- zera_placar coinciding with a score increment: the clear wins.
- Reset asserted mid-round: immediate return to the reset values above.
- Unused state codes -> OCIOSO; db_estado = 4'hB.

Test Plan:
- Reset, inicia_rodada, botoes=0100 rising -> concede=0100 one cycle after the press edge; jogador_id=2; resposta_pronta&certa -> placar[2]=1, rodada_fim pulse with houve_vencedor=1, state returns to 0.
- Armed, botoes 0000->1010 in the same cycle with pointer 0 -> grant player 1; next round with the same simultaneous press -> grant player 3 (pointer now 2).
- Grant player 0, wrong answer -> bloqueados=0001, state ARMADO; player 0 presses again -> no grant; player 2 presses -> concede=0100.
- Grant with no answer for TEMPO_RESPOSTA cycles (use TEMPO_RESPOSTA=8 in the bench) -> concede drops after exactly 8 grant cycles, player blocked; all 4 players time out in turn -> rodada_fim with houve_vencedor=0, scores unchanged.
- PLACAR_W=4, player 1 wins 16 rounds -> placar[1] stays 15; zera_placar -> all scores 0 next cycle.
- cancela during CONCEDIDO -> ativo=0 next cycle, no rodada_fim, no score change; button held through a new inicia_rodada -> no grant until it is released and pressed again.
